rx_pdu_ctrl: RTL and testbench
==============================

Name: rx_pdu_ctrl

Overview:
Packet-level controller directly downstream of the RX bit/byte datapath (access-address search, de-whitening, serial-to-parallel, FIFO, CRC). It arms the RX path, pops received bytes from the RX FIFO, parses the 2-byte PDU header and stores the payload in a local byte buffer. It then samples the CRC result and reports done, crc_ok, timeout and overflow status to the CPU register bank.

Parameters:
BUF_DEPTH, 64, payload buffer depth in bytes; must be a power of 2; bytes beyond this are dropped.
BUF_AW, 6, buffer address width, log2(BUF_DEPTH).
TO_W, 24, timeout counter width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  global enable; when low, timeout counter and FSM hold their state
start  in  1  one-cycle pulse: begin a new packet reception
abort  in  1  one-cycle pulse: return to IDLE, no status update
timeout  in  TO_W  cycles allowed from start to done; 0 = no timeout
rx_start  out  1  one-cycle pulse to RX path (flushes FIFO, clears aa_found/crc_valid)
rx_rd_en  out  1  FIFO pop strobe
rx_data  in  8  FIFO data; valid the cycle after rx_rd_en
rx_empty  in  1  FIFO empty
rx_aa_found  in  1  access address found
rx_crc_valid  in  1  sticky CRC-residue-zero flag
buf_addr  in  BUF_AW  CPU read address into payload buffer
buf_data  out  8  payload byte, registered, valid 1 cycle after buf_addr
hdr  out  16  {byte1, byte0} of PDU header
pdu_len  out  8  length field (header byte1)
busy  out  1  FSM not in IDLE/DONE
done  out  1  sticky; set on completion or timeout; cleared by start
crc_ok  out  1  sampled rx_crc_valid at completion
to_err  out  1  timeout occurred
ovf  out  1  pdu_len > BUF_DEPTH

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters cleared. Buffer contents undefined.
- States: IDLE, ARM, WAIT_AA, HDR0, HDR1, PAYLOAD, CRC, CHECK, DONE.
- start (from any state, including mid-packet): clear done/crc_ok/to_err/ovf/hdr, go to ARM. start has priority over abort. abort -> IDLE.
- ARM: rx_start=1 for exactly 1 cycle, load timeout counter, then go to WAIT_AA.
- WAIT_AA: wait for rx_aa_found=1, then go to HDR0.
- Pop rule for the read states HDR0/HDR1/PAYLOAD/CRC:
  - Assert rx_rd_en for one cycle when rx_empty=0 and no pop is pending.
  - Capture rx_data on the next cycle; maximum rate is 1 byte per 2 cycles.
  - Never pop when empty.
- HDR0: capture into hdr[7:0].
- HDR1: capture into hdr[15:8] and pdu_len; set ovf = (pdu_len > BUF_DEPTH).
  - pdu_len=0: go to CRC.
  - Otherwise: go to PAYLOAD.
- PAYLOAD: write byte i to buf[i] for i < BUF_DEPTH; drop bytes with i >= BUF_DEPTH but still pop them. After pdu_len bytes, go to CRC.
- CRC: pop 3 bytes, discard them, go to CHECK.
- CHECK: wait 2 cycles for the CRC LFSR to settle, then go to DONE with crc_ok=rx_crc_valid and done=1.
- DONE: hold status until start or abort. Buffer stays readable in every state.
- Timeout:
  - Counter decrements each en cycle in WAIT_AA..CHECK when timeout != 0.
  - Reaching 0 -> DONE with to_err=1, crc_ok=0, done=1.
  - Completion and expiry in the same cycle: completion wins, to_err=0.
- Byte counter is 8-bit; the 255-byte maximum must not wrap early.

Decomposition:
- Shared package/header holds:
  - state encodings (4-bit);
  - RX_HDR_BYTES=2;
  - RX_CRC_BYTES=3;
  - CHECK_WAIT=2.
- One sub-module: rx_pdu_buf, a simple dual-port byte RAM (write from FSM, registered read from CPU), BUF_DEPTH x 8.

Test Plan:
- Nominal packet: start, aa_found, FIFO supplies 0x02,0x05, payload 11 22 33 44 55, CRC bytes, then crc_valid=1 -> hdr=0x0502, pdu_len=5, buf[0..4]=11..55, done=1, crc_ok=1, to_err=0, exactly 10 pops.
- Bad CRC: same packet with rx_crc_valid held 0 -> done=1, crc_ok=0, buffer still filled.
- Zero length: header 0x00,0x00 -> exactly 5 pops total, done=1, pdu_len=0.
- Overflow: pdu_len=0x50 with BUF_DEPTH=64 -> ovf=1; 85 pops; buf[63] holds byte 63; byte 64 is not written.
- Timeout: timeout=100, aa_found never asserted -> done=1 and to_err=1 exactly 100 en-cycles after the ARM load. With timeout=0 the block waits indefinitely.
- Restart mid-packet: second start during PAYLOAD -> rx_start pulses again, status cleared, second packet parsed correctly. FIFO empty gaps of 20 cycles between bytes cause no extra pops.

Source files
------------

// File: rtl/rx_pdu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rx_pdu_ctrl_pkg
// Shared definitions for the RX packet-level controller:
//   - 4-bit FSM state encodings
//   - fixed packet framing sizes (header / CRC byte counts)
//   - settle time allowed for the CRC LFSR before sampling its result
//   - small state-class helpers used by the controller
// ---------------------------------------------------------------------------
package rx_pdu_ctrl_pkg;

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_ARM     = 4'd1;
   localparam logic [3:0] ST_WAIT_AA = 4'd2;
   localparam logic [3:0] ST_HDR0    = 4'd3;
   localparam logic [3:0] ST_HDR1    = 4'd4;
   localparam logic [3:0] ST_PAYLOAD = 4'd5;
   localparam logic [3:0] ST_CRC     = 4'd6;
   localparam logic [3:0] ST_CHECK   = 4'd7;
   localparam logic [3:0] ST_DONE    = 4'd8;

   localparam int RX_HDR_BYTES = 2;
   localparam int RX_CRC_BYTES = 3;
   localparam int CHECK_WAIT   = 2;

   // States that pull bytes out of the RX FIFO.
   function automatic logic is_read_state(input logic [3:0] s);
      return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_PAYLOAD) || (s == ST_CRC);
   endfunction

   // States during which the timeout counter runs (WAIT_AA through CHECK).
   function automatic logic is_timed_state(input logic [3:0] s);
      return (s >= ST_WAIT_AA) && (s <= ST_CHECK);
   endfunction

endpackage

// File: rtl/rx_pdu_buf.sv
// ---------------------------------------------------------------------------
// rx_pdu_buf
// Simple dual-port payload byte RAM, DEPTH x 8.
//   clk    : system clock
//   rst    : asynchronous active-high reset (read data register only)
//   we     : write strobe from the controller FSM
//   waddr  : write address
//   wdata  : write byte
//   raddr  : CPU read address
//   rdata  : registered read byte, valid one cycle after raddr
// Array contents are not reset; only the output register is.
// ---------------------------------------------------------------------------
module rx_pdu_buf #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/rx_pdu_ctrl.sv
// ---------------------------------------------------------------------------
// rx_pdu_ctrl
// Packet-level RX controller. Arms the RX path, pops bytes from the RX FIFO,
// parses the 2-byte PDU header, stores the payload into a local byte buffer,
// discards the CRC bytes, samples the CRC result and reports status.
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   en             : global enable; when low the FSM and timeout counter hold
//   start, abort   : one-cycle command pulses (start has priority)
//   timeout        : cycles allowed from arming to done, 0 = unlimited
//   rx_start       : one-cycle pulse to the RX path (flush / re-arm)
//   rx_rd_en       : FIFO pop strobe
//   rx_data        : FIFO byte, valid the cycle after rx_rd_en
//   rx_empty       : FIFO empty
//   rx_aa_found    : access address detected
//   rx_crc_valid   : sticky CRC-good flag
//   buf_addr/data  : CPU read port into the payload buffer (1-cycle latency)
//   hdr, pdu_len   : captured header {byte1, byte0} and its length field
//   busy           : FSM is neither IDLE nor DONE
//   done, crc_ok,
//   to_err, ovf    : packet status, cleared by start
// ---------------------------------------------------------------------------
module rx_pdu_ctrl
   import rx_pdu_ctrl_pkg::*;
#(
   parameter int BUF_DEPTH = 64,
   parameter int BUF_AW    = 6,
   parameter int TO_W      = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              start,
   input  logic              abort,
   input  logic [TO_W-1:0]   timeout,
   output logic              rx_start,
   output logic              rx_rd_en,
   input  logic [7:0]        rx_data,
   input  logic              rx_empty,
   input  logic              rx_aa_found,
   input  logic              rx_crc_valid,
   input  logic [BUF_AW-1:0] buf_addr,
   output logic [7:0]        buf_data,
   output logic [15:0]       hdr,
   output logic [7:0]        pdu_len,
   output logic              busy,
   output logic              done,
   output logic              crc_ok,
   output logic              to_err,
   output logic              ovf
);

   logic [3:0]      state_reg;
   logic [TO_W-1:0] to_cnt_reg;
   logic [7:0]      byte_cnt_reg;
   logic [1:0]      wait_cnt_reg;
   logic            pending_reg;
   logic [15:0]     hdr_reg;
   logic            done_reg;
   logic            crc_ok_reg;
   logic            to_err_reg;
   logic            ovf_reg;

   logic            cmd;
   logic            read_state;
   logic            capture;
   logic            in_range;
   logic            buf_we;
   logic            check_done;
   logic            expire;

   // Any command pulse pre-empts the datapath for this cycle.
   assign cmd        = start | abort;
   assign read_state = is_read_state(state_reg);

   // A pop is issued only when nothing is in flight, so the byte captured
   // next cycle is unambiguously the one just popped (max 1 byte / 2 cycles).
   assign rx_rd_en = en && !cmd && read_state && !pending_reg && !rx_empty;
   assign capture  = en && !cmd && read_state && pending_reg;

   // Compare in 9 bits so BUF_DEPTH=256 and byte index 255 behave correctly.
   assign in_range = ({1'b0, byte_cnt_reg} < 9'(BUF_DEPTH));
   assign buf_we   = capture && (state_reg == ST_PAYLOAD) && in_range;

   assign check_done = (state_reg == ST_CHECK) && (wait_cnt_reg == 2'(CHECK_WAIT - 1));
   // Counter is loaded with 0 for "no timeout"; it then never reaches 1.
   assign expire     = is_timed_state(state_reg) && (to_cnt_reg == TO_W'(1));

   assign rx_start = en && !cmd && (state_reg == ST_ARM);
   assign hdr      = hdr_reg;
   assign pdu_len  = hdr_reg[15:8];
   assign busy     = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
   assign done     = done_reg;
   assign crc_ok   = crc_ok_reg;
   assign to_err   = to_err_reg;
   assign ovf      = ovf_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         to_cnt_reg   <= '0;
         byte_cnt_reg <= '0;
         wait_cnt_reg <= '0;
         pending_reg  <= 1'b0;
         hdr_reg      <= '0;
         done_reg     <= 1'b0;
         crc_ok_reg   <= 1'b0;
         to_err_reg   <= 1'b0;
         ovf_reg      <= 1'b0;
      end else if (en) begin
         if (start) begin
            state_reg    <= ST_ARM;
            byte_cnt_reg <= '0;
            wait_cnt_reg <= '0;
            pending_reg  <= 1'b0;
            hdr_reg      <= '0;
            done_reg     <= 1'b0;
            crc_ok_reg   <= 1'b0;
            to_err_reg   <= 1'b0;
            ovf_reg      <= 1'b0;
         end else if (abort) begin
            state_reg   <= ST_IDLE;
            pending_reg <= 1'b0;
         end else begin
            pending_reg <= rx_rd_en;

            if (is_timed_state(state_reg) && (to_cnt_reg != '0)) begin
               to_cnt_reg <= to_cnt_reg - 1'b1;
            end

            // Completion outranks a timeout expiring on the same cycle.
            if (check_done) begin
               state_reg  <= ST_DONE;
               done_reg   <= 1'b1;
               crc_ok_reg <= rx_crc_valid;
            end else if (expire) begin
               state_reg   <= ST_DONE;
               done_reg    <= 1'b1;
               to_err_reg  <= 1'b1;
               crc_ok_reg  <= 1'b0;
               pending_reg <= 1'b0;
            end else begin
               case (state_reg)
                  ST_IDLE: ;
                  ST_ARM: begin
                     to_cnt_reg <= timeout;
                     state_reg  <= ST_WAIT_AA;
                  end
                  ST_WAIT_AA: begin
                     if (rx_aa_found) begin
                        state_reg <= ST_HDR0;
                     end
                  end
                  ST_HDR0: begin
                     if (capture) begin
                        hdr_reg[7:0] <= rx_data;
                        state_reg    <= ST_HDR1;
                     end
                  end
                  ST_HDR1: begin
                     if (capture) begin
                        hdr_reg[15:8] <= rx_data;
                        ovf_reg       <= ({1'b0, rx_data} > 9'(BUF_DEPTH));
                        byte_cnt_reg  <= '0;
                        state_reg     <= (rx_data == 8'd0) ? ST_CRC : ST_PAYLOAD;
                     end
                  end
                  ST_PAYLOAD: begin
                     // pdu_len >= 1 here, so pdu_len-1 cannot wrap and the
                     // counter tops out at 254 for a 255-byte payload.
                     if (capture) begin
                        if (byte_cnt_reg == (hdr_reg[15:8] - 8'd1)) begin
                           byte_cnt_reg <= '0;
                           state_reg    <= ST_CRC;
                        end else begin
                           byte_cnt_reg <= byte_cnt_reg + 8'd1;
                        end
                     end
                  end
                  ST_CRC: begin
                     if (capture) begin
                        if (byte_cnt_reg == 8'(RX_CRC_BYTES - 1)) begin
                           wait_cnt_reg <= '0;
                           state_reg    <= ST_CHECK;
                        end else begin
                           byte_cnt_reg <= byte_cnt_reg + 8'd1;
                        end
                     end
                  end
                  ST_CHECK: begin
                     wait_cnt_reg <= wait_cnt_reg + 2'd1;
                  end
                  ST_DONE: ;
                  default: begin
                     state_reg <= ST_IDLE;
                  end
               endcase
            end
         end
      end
   end

   rx_pdu_buf #(
      .DEPTH (BUF_DEPTH),
      .AW    (BUF_AW)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (buf_we),
      .waddr (byte_cnt_reg[BUF_AW-1:0]),
      .wdata (rx_data),
      .raddr (buf_addr),
      .rdata (buf_data)
   );

endmodule

// File: tb/tb_rx_pdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_pdu_ctrl
// Self-checking bench: a queue-based RX FIFO / access-address model drives
// the controller; expected results are derived from the packet bytes alone.
// ---------------------------------------------------------------------------
module tb_rx_pdu_ctrl;

   localparam int BUF_DEPTH = 64;
   localparam int BUF_AW    = 6;
   localparam int TO_W      = 24;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [TO_W-1:0]   timeout = '0;
   logic              rx_start;
   logic              rx_rd_en;
   logic [7:0]        rx_data = '0;
   logic              rx_empty = 1'b1;
   logic              rx_aa_found = 1'b0;
   logic              rx_crc_valid = 1'b0;
   logic [BUF_AW-1:0] buf_addr = '0;
   logic [7:0]        buf_data;
   logic [15:0]       hdr;
   logic [7:0]        pdu_len;
   logic              busy;
   logic              done;
   logic              crc_ok;
   logic              to_err;
   logic              ovf;

   always #5 clk = ~clk;

   rx_pdu_ctrl #(
      .BUF_DEPTH (BUF_DEPTH),
      .BUF_AW    (BUF_AW),
      .TO_W      (TO_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .start        (start),
      .abort        (abort),
      .timeout      (timeout),
      .rx_start     (rx_start),
      .rx_rd_en     (rx_rd_en),
      .rx_data      (rx_data),
      .rx_empty     (rx_empty),
      .rx_aa_found  (rx_aa_found),
      .rx_crc_valid (rx_crc_valid),
      .buf_addr     (buf_addr),
      .buf_data     (buf_data),
      .hdr          (hdr),
      .pdu_len      (pdu_len),
      .busy         (busy),
      .done         (done),
      .crc_ok       (crc_ok),
      .to_err       (to_err),
      .ovf          (ovf)
   );

   // Checking bookkeeping
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // RX path model state
   logic [7:0] src_q[$];     // bytes the air interface will deliver
   logic [7:0] fifo_q[$];    // bytes sitting in the RX FIFO
   logic [7:0] pkt_q[$];     // reference copy of the current packet
   int  aa_delay   = 1;      // cycles from rx_start to aa_found, -1 = never
   int  aa_cnt     = -1;
   bit  aa         = 1'b0;
   int  feed_gap   = 0;
   int  gap_cnt    = 0;
   bit  crc_good   = 1'b1;
   int  pop_cnt    = 0;
   int  start_cnt  = 0;
   int  empty_pops = 0;

   // One clock cycle: observe DUT strobes mid-cycle, then apply the FIFO
   // and RX-path reaction just after the active edge.
   task automatic tick();
      bit s_rd;
      bit s_st;
      @(negedge clk);
      s_rd = rx_rd_en;
      s_st = rx_start;
      if (s_rd && rx_empty) empty_pops++;
      @(posedge clk);
      #1;
      if (s_st) begin
         fifo_q.delete();
         aa        = 1'b0;
         aa_cnt    = aa_delay;
         gap_cnt   = 0;
         pop_cnt   = 0;
         start_cnt++;
      end else if (s_rd) begin
         pop_cnt++;
         if (fifo_q.size() > 0) rx_data = fifo_q.pop_front();
      end
      if (!aa && aa_cnt >= 0) begin
         if (aa_cnt == 0) aa = 1'b1;
         else aa_cnt--;
      end
      if (aa && src_q.size() > 0) begin
         if (gap_cnt == 0) begin
            fifo_q.push_back(src_q.pop_front());
            gap_cnt = feed_gap;
         end else begin
            gap_cnt--;
         end
      end
      rx_aa_found  = aa;
      rx_empty     = (fifo_q.size() == 0);
      rx_crc_valid = crc_good && aa && (src_q.size() == 0);
   endtask

   task automatic build_pkt(input int len, input int b0);
      pkt_q.delete();
      pkt_q.push_back(8'(b0));
      pkt_q.push_back(8'(len));
      for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < 3; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
   endtask

   // Start a reception of pkt_q; the RX path drops aa and data on start.
   task automatic issue_start();
      src_q  = pkt_q;
      aa     = 1'b0;
      aa_cnt = -1;
      rx_aa_found  = 1'b0;
      rx_crc_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic read_buf(input int addr, output logic [7:0] val);
      buf_addr = BUF_AW'(addr);
      tick();
      val = buf_data;
   endtask

   // Send pkt_q and compare every status output and buffer byte against
   // what the packet itself dictates.
   task automatic send_and_check(input string name);
      int len;
      int n;
      int st0;
      int viol0;
      logic [7:0] b;
      len   = int'(pkt_q[1]);
      st0   = start_cnt;
      viol0 = empty_pops;
      issue_start();
      check_val({name, "_clr_done"}, 32'(done), 32'd0);
      check_val({name, "_clr_hdr"}, 32'(hdr), 32'd0);
      n = 0;
      while (!done && n < 4000) begin
         tick();
         n++;
      end
      check_val({name, "_done"}, 32'(done), 32'd1);
      check_val({name, "_hdr"}, 32'(hdr), {16'd0, pkt_q[1], pkt_q[0]});
      check_val({name, "_len"}, 32'(pdu_len), 32'(len));
      check_val({name, "_crc_ok"}, 32'(crc_ok), 32'(crc_good));
      check_val({name, "_to_err"}, 32'(to_err), 32'd0);
      check_val({name, "_ovf"}, 32'(ovf), 32'(len > BUF_DEPTH));
      check_val({name, "_busy"}, 32'(busy), 32'd0);
      check_val({name, "_pops"}, 32'(pop_cnt), 32'(len + 5));
      check_val({name, "_rx_start"}, 32'(start_cnt - st0), 32'd1);
      check_val({name, "_empty_pop"}, 32'(empty_pops - viol0), 32'd0);
      for (int i = 0; i < len && i < BUF_DEPTH; i++) begin
         read_buf(i, b);
         check_val($sformatf("%s_buf%0d", name, i), 32'(b), 32'(pkt_q[2 + i]));
      end
      $display("pkt %s len=%0d gap=%0d pops=%0d hdr=%04h crc_ok=%0d ovf=%0d",
               name, len, feed_gap, pop_cnt, hdr, crc_ok, ovf);
   endtask

   initial begin
      int first;
      int en_cnt;
      int n;
      logic [7:0] b;

      // Reset: everything zero while rst is held.
      repeat (3) tick();
      check_val("rst_rx_start", 32'(rx_start), 32'd0);
      check_val("rst_rd_en", 32'(rx_rd_en), 32'd0);
      check_val("rst_buf_data", 32'(buf_data), 32'd0);
      check_val("rst_hdr", 32'(hdr), 32'd0);
      check_val("rst_pdu_len", 32'(pdu_len), 32'd0);
      check_val("rst_status", {27'd0, busy, done, crc_ok, to_err, ovf}, 32'd0);
      rst = 1'b0;
      repeat (2) tick();
      check_val("idle_busy", 32'(busy), 32'd0);

      // Nominal packet 02 05 11 22 33 44 55 + CRC
      timeout = 24'd5000;
      pkt_q = '{8'h02, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA1, 8'hB2, 8'hC3};
      crc_good = 1'b1; feed_gap = 0; aa_delay = 2;
      send_and_check("nominal");

      // Same packet with a failing CRC
      crc_good = 1'b0;
      send_and_check("bad_crc");

      // Zero-length payload, with timeout disabled
      crc_good = 1'b1; timeout = '0;
      pkt_q = '{8'h00, 8'h00, 8'h12, 8'h34, 8'h56};
      send_and_check("zero_len");

      // Buffer-size boundaries: 64 fits, 65 and 0x50 overflow, 255 max
      timeout = 24'd5000;
      build_pkt(64, 1);  send_and_check("len64");
      build_pkt(65, 2);  send_and_check("len65");
      build_pkt(80, 3);  send_and_check("ovf80");
      build_pkt(255, 4); send_and_check("len255");

      // Randomized packets
      for (int k = 0; k < 6; k++) begin
         build_pkt($urandom_range(0, 100), $urandom_range(0, 255));
         crc_good = $urandom_range(0, 1);
         feed_gap = $urandom_range(0, 3);
         aa_delay = $urandom_range(0, 6);
         send_and_check($sformatf("rand%0d", k));
      end

      // Timeout with aa never found; en toggled, expiry counted in en-cycles
      feed_gap = 0; aa_delay = -1; timeout = 24'd100;
      pkt_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      issue_start();
      tick();                        // ARM: loads the counter
      first = -1; en_cnt = 0;
      for (int i = 0; i < 1000 && first < 0; i++) begin
         en = ($urandom_range(0, 3) != 0);
         tick();
         if (en) en_cnt++;
         if (done && first < 0) first = en_cnt;
      end
      en = 1'b1;
      check_val("to100_cycles", 32'(first), 32'd100);
      check_val("to100_to_err", 32'(to_err), 32'd1);
      check_val("to100_crc_ok", 32'(crc_ok), 32'd0);
      check_val("to100_busy", 32'(busy), 32'd0);
      $display("pkt timeout100 en_cycles=%0d to_err=%0d", first, to_err);

      // timeout = 0 waits indefinitely; abort then returns to idle
      timeout = '0;
      issue_start();
      repeat (300) tick();
      check_val("to0_done", 32'(done), 32'd0);
      check_val("to0_busy", 32'(busy), 32'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_done", 32'(done), 32'd0);
      $display("pkt timeout0 waited=300 then abort busy=%0d", busy);

      // Timeout expiring mid-payload
      timeout = 24'd50; aa_delay = 1; feed_gap = 3; crc_good = 1'b1;
      build_pkt(60, 9);
      issue_start();
      n = 0;
      while (!done && n < 2000) begin tick(); n++; end
      check_val("to_pl_done", 32'(done), 32'd1);
      check_val("to_pl_to_err", 32'(to_err), 32'd1);
      check_val("to_pl_crc_ok", 32'(crc_ok), 32'd0);
      $display("pkt timeout_payload pops=%0d to_err=%0d", pop_cnt, to_err);

      // Restart in the middle of a payload, second packet with 20-cycle gaps
      timeout = 24'd20000; feed_gap = 2; aa_delay = 1;
      build_pkt(40, 7);
      issue_start();
      n = 0;
      while (pop_cnt < 8 && n < 2000) begin tick(); n++; end
      check_val("restart_mid_busy", 32'(busy), 32'd1);
      check_val("restart_mid_pops", 32'(pop_cnt >= 8), 32'd1);
      $display("pkt restart_first len=40 popped=%0d before restart", pop_cnt);
      feed_gap = 20;
      build_pkt(12, 8'h5A);
      send_and_check("restart");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
